// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: machine word, next-PC source select
// and default return-address-stack depth.
package cpu_types_pkg;

  localparam int CPU_WORD_W    = 32;
  localparam int RAS_DEPTH_DEF = 4;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    PCSEL_SEQ,
    PCSEL_REDIR,
    PCSEL_PEND,
    PCSEL_JUMP,
    PCSEL_RAS
  } pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and the occupancy count saturates at DEPTH.
module pc_ras
  import cpu_types_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH_DEF,
  parameter int WORD_W = CPU_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] push_data,
  output logic [WORD_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;

  // ptr names the next slot to write; the top of stack sits one below it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (pop) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage has no reset; entries are only read once count says they were written.
  always_ff @(posedge CLK) begin
    if (push) mem[ptr] <= push_data;
  end

  assign top   = mem[ptr - PTR_W'(1)];
  assign empty = (count == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with EX redirect capture, early J/JAL resolution, a sticky
// halt latch and, when PC_RAS_EN is defined, JR $31 prediction from a return-address stack.
module pc_fetch_ctrl
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = 32'h0,
  parameter int          WORD_W    = 32,
  parameter int          RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              stall,
  input  logic              halt,
  input  logic              redir_valid,
  input  logic [WORD_W-1:0] redir_addr,
  input  logic              dec_valid,
  input  logic [WORD_W-1:0] dec_pc,
  input  logic              dec_jump,
  input  logic              dec_jal,
  input  logic              dec_jr_ra,
  input  logic [WORD_W-7:0] dec_jaddr,
  output logic [WORD_W-1:0] PCAddr,
  output logic              halted,
  output logic              ras_pred,
  output logic              redir_pending
);

  logic              fe, adv;
  logic              id_live, ras_hit, ras_push, ras_empty;
  logic [WORD_W-1:0] pend_addr, next_pc, dec_link, ras_top;
  pc_sel_t           sel;

  assign fe       = ihit & ~stall & ~halted;
  assign adv      = fe & ~halt;
  assign dec_link = dec_pc + WORD_W'(4);
  // A live or pending redirect squashes whatever ID holds.
  assign id_live  = dec_valid & ~redir_valid & ~redir_pending;
  assign ras_hit  = id_live & dec_jr_ra & ~ras_empty;
  assign ras_push = adv & id_live & dec_jal;

`ifdef PC_RAS_EN
  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WORD_W(WORD_W)
  ) u_ras (
    .CLK      (CLK),
    .RST      (RST),
    .push     (ras_push),
    .pop      (adv && sel == PCSEL_RAS),
    .push_data(dec_link),
    .top      (ras_top),
    .empty    (ras_empty)
  );
`else
  logic unused_cfg;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_cfg = ^{dec_link[WORD_W-5:0], ras_push, (RAS_DEPTH > 1)};
`endif

  always_comb begin
    sel     = PCSEL_SEQ;
    next_pc = PCAddr + WORD_W'(4);
    if (redir_valid)              sel = PCSEL_REDIR;
    else if (redir_pending)       sel = PCSEL_PEND;
    else if (dec_valid & dec_jump) sel = PCSEL_JUMP;
    else if (ras_hit)             sel = PCSEL_RAS;
    case (sel)
      PCSEL_REDIR: next_pc = redir_addr;
      PCSEL_PEND:  next_pc = pend_addr;
      PCSEL_JUMP:  next_pc = {dec_link[WORD_W-1:WORD_W-4], dec_jaddr, 2'b00};
      PCSEL_RAS:   next_pc = ras_top;
      default:     next_pc = PCAddr + WORD_W'(4);
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PCAddr        <= WORD_W'(PC_INIT);
      pend_addr     <= '0;
      redir_pending <= 1'b0;
      halted        <= 1'b0;
      ras_pred      <= 1'b0;
    end else if (halt) begin
      halted        <= 1'b1;
      redir_pending <= 1'b0;
    end else if (adv) begin
      PCAddr        <= next_pc;
      redir_pending <= 1'b0;
      ras_pred      <= (sel == PCSEL_RAS);
    end else if (redir_valid && !halted) begin
      pend_addr     <= redir_addr;
      redir_pending <= 1'b1;
    end
  end

endmodule
